// File: rtl/abr_1r1w_ram_arb.sv
// Round-robin arbiter and clear sequencer in front of a 1R1W synchronous RAM.
// Define ABR_RAM_ARB_FWD_EN to forward same-cycle write data to a colliding read.
module abr_1r1w_ram_arb #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int NUM_REQ    = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             zeroize_i,
    output logic                             busy_o,
    input  logic [NUM_REQ-1:0]               wr_req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    wr_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    wr_data_i,
    output logic [NUM_REQ-1:0]               wr_gnt_o,
    input  logic [NUM_REQ-1:0]               rd_req_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    rd_addr_i,
    output logic [NUM_REQ-1:0]               rd_gnt_o,
    output logic [NUM_REQ-1:0]               rd_valid_o,
    output logic [DATA_WIDTH-1:0]            rd_data_o,
    output logic                             ram_we_o,
    output logic [ADDR_WIDTH-1:0]            ram_waddr_o,
    output logic [DATA_WIDTH-1:0]            ram_wdata_o,
    output logic                             ram_re_o,
    output logic [ADDR_WIDTH-1:0]            ram_raddr_o,
    input  logic [DATA_WIDTH-1:0]            ram_rdata_i
);

    localparam int unsigned IDXW   = $clog2(NUM_REQ);
    localparam int unsigned NREQ_U = NUM_REQ;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [IDXW-1:0]       RST_PTR   = IDXW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0]    ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic {CLEAR, READY} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
    logic [IDXW-1:0]        wr_last_q, rd_last_q;
    logic [NUM_REQ-1:0]     rd_vld_q;
    logic [IDXW:0]          wr_pick, rd_pick;
    logic [IDXW-1:0]        wr_idx, rd_idx;
    logic                   gnt_en;
    logic [DATA_WIDTH-1:0]  rd_word;

    // Returns {found, index}; scans offsets NUM_REQ..1 so the smallest offset after 'last' wins.
    function automatic logic [IDXW:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [IDXW-1:0]    last);
        logic [IDXW:0] pick;
        int unsigned   cand;
        pick = '0;
        for (int unsigned k = 0; k < NREQ_U; k++) begin
            cand = 32'(last) + (NREQ_U - k);
            if (cand >= NREQ_U) cand = cand - NREQ_U;
            if (req[cand[IDXW-1:0]]) pick = {1'b1, cand[IDXW-1:0]};
        end
        return pick;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                if (zeroize_i) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_ADDR) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READY: begin
                if (zeroize_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    assign gnt_en  = (state_q == READY) && !zeroize_i && !rst_i;
    assign wr_pick = rr_pick(wr_req_i, wr_last_q);
    assign rd_pick = rr_pick(rd_req_i, rd_last_q);
    assign wr_idx  = wr_pick[IDXW-1:0];
    assign rd_idx  = rd_pick[IDXW-1:0];

    always_comb begin
        busy_o      = rst_i || (state_q == CLEAR);
        wr_gnt_o    = '0;
        rd_gnt_o    = '0;
        ram_we_o    = 1'b0;
        ram_waddr_o = '0;
        ram_wdata_o = '0;
        ram_re_o    = 1'b0;
        ram_raddr_o = '0;
        if (!rst_i) begin
            if (state_q == CLEAR) begin
                ram_we_o    = 1'b1;
                ram_waddr_o = cnt_q;
            end else if (gnt_en) begin
                if (wr_pick[IDXW]) begin
                    wr_gnt_o    = ONE_HOT0 << wr_idx;
                    ram_we_o    = 1'b1;
                    ram_waddr_o = wr_addr_i[wr_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    ram_wdata_o = wr_data_i[wr_idx*DATA_WIDTH +: DATA_WIDTH];
                end
                if (rd_pick[IDXW]) begin
                    rd_gnt_o    = ONE_HOT0 << rd_idx;
                    ram_re_o    = 1'b1;
                    ram_raddr_o = rd_addr_i[rd_idx*ADDR_WIDTH +: ADDR_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_last_q <= RST_PTR;
            rd_last_q <= RST_PTR;
            rd_vld_q  <= '0;
        end else begin
            if (|wr_gnt_o) wr_last_q <= wr_idx;
            if (|rd_gnt_o) rd_last_q <= rd_idx;
            rd_vld_q <= rd_gnt_o;
        end
    end

`ifdef ABR_RAM_ARB_FWD_EN
    logic                  fwd_hit_q;
    logic [DATA_WIDTH-1:0] fwd_data_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_hit_q  <= ram_re_o && ram_we_o && (ram_raddr_o == ram_waddr_o);
            fwd_data_q <= ram_wdata_o;
        end
    end

    assign rd_word = fwd_hit_q ? fwd_data_q : ram_rdata_i;
`else
    assign rd_word = ram_rdata_i;
`endif

    // A reset arriving the cycle after a grant must suppress the already-registered valid.
    assign rd_valid_o = rst_i ? '0 : rd_vld_q;
    assign rd_data_o  = (|rd_valid_o) ? rd_word : '0;

endmodule

// File: tb/tb_abr_1r1w_ram_arb.sv
// Scoreboard bench for abr_1r1w_ram_arb: cycle-level reference model plus read-data monitor.
module tb_abr_1r1w_ram_arb;
    localparam int DEPTH = 64;
    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int NREQ  = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             zeroize = 1'b0;
    logic             busy;
    logic [NREQ-1:0]    wr_req = '0;
    logic [NREQ*AW-1:0] wr_addr = '0;
    logic [NREQ*DW-1:0] wr_data = '0;
    logic [NREQ-1:0]    wr_gnt;
    logic [NREQ-1:0]    rd_req = '0;
    logic [NREQ*AW-1:0] rd_addr = '0;
    logic [NREQ-1:0]    rd_gnt;
    logic [NREQ-1:0]    rd_valid;
    logic [DW-1:0]      rd_data;
    logic               ram_we, ram_re;
    logic [AW-1:0]      ram_waddr, ram_raddr;
    logic [DW-1:0]      ram_wdata;
    logic [DW-1:0]      ram_rdata = '0;

    abr_1r1w_ram_arb #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NREQ)) dut (
        .clk_i(clk), .rst_i(rst), .zeroize_i(zeroize), .busy_o(busy),
        .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_gnt_o(wr_gnt),
        .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt),
        .rd_valid_o(rd_valid), .rd_data_o(rd_data),
        .ram_we_o(ram_we), .ram_waddr_o(ram_waddr), .ram_wdata_o(ram_wdata),
        .ram_re_o(ram_re), .ram_raddr_o(ram_raddr), .ram_rdata_i(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM macro stand-in: registered read, read-first; filled with a nonzero pattern while in reset.
    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < DEPTH; a++) ram_mem[a] <= 32'hA5A5_0000 | DW'(a + 1);
        end else if (ram_we) begin
            ram_mem[ram_waddr] <= ram_wdata;
        end
        if (ram_re) ram_rdata <= ram_mem[ram_raddr];
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endtask

    typedef struct { int due; int idx; logic [DW-1:0] data; } rd_exp_t;
    rd_exp_t rq[$];

    // Reference model state
    logic [DW-1:0] mem_m [DEPTH];
    int wlast = NREQ - 1, rlast = NREQ - 1;
    int ready_at = 0;

    function automatic int rr_next(input logic [NREQ-1:0] req, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (last + k) % NREQ;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    initial begin : model
        bit busy_e, en;
        int wj, rj, clr;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd, d;
        forever begin
            @(negedge clk);
            busy_e = rst || (cyc < ready_at);
            en = !busy_e && !zeroize;
            wj = en ? rr_next(wr_req, wlast) : -1;
            rj = en ? rr_next(rd_req, rlast) : -1;
            chk("busy", 64'(busy), 64'(busy_e));
            chk("wr_gnt", 64'(wr_gnt), wj >= 0 ? (64'd1 << wj) : 64'd0);
            chk("rd_gnt", 64'(rd_gnt), rj >= 0 ? (64'd1 << rj) : 64'd0);
            if (rst) begin
                chk("ram_we_rst", 64'(ram_we), 64'd0);
                chk("ram_re_rst", 64'(ram_re), 64'd0);
                chk("ram_ports_rst", 64'({ram_waddr, ram_raddr, ram_wdata}), 64'd0);
                rq.delete();
                wlast = NREQ - 1;
                rlast = NREQ - 1;
                ready_at = cyc + 1 + DEPTH;
            end else if (busy_e) begin
                clr = cyc - (ready_at - DEPTH);
                chk("ram_we_clr", 64'(ram_we), 64'd1);
                chk("ram_waddr_clr", 64'(ram_waddr), 64'(clr));
                chk("ram_wdata_clr", 64'(ram_wdata), 64'd0);
                chk("ram_re_clr", 64'(ram_re), 64'd0);
                mem_m[clr] = '0;
                if (zeroize) ready_at = cyc + 1 + DEPTH;
            end else begin
                wa = wj >= 0 ? wr_addr[wj*AW +: AW] : '0;
                wd = wj >= 0 ? wr_data[wj*DW +: DW] : '0;
                ra = rj >= 0 ? rd_addr[rj*AW +: AW] : '0;
                chk("ram_we", 64'(ram_we), 64'(wj >= 0));
                chk("ram_re", 64'(ram_re), 64'(rj >= 0));
                if (wj >= 0) chk("ram_wport", 64'({ram_waddr, ram_wdata}), 64'({wa, wd}));
                if (rj >= 0) begin
                    chk("ram_raddr", 64'(ram_raddr), 64'(ra));
                    d = mem_m[ra];
`ifdef ABR_RAM_ARB_FWD_EN
                    if (wj >= 0 && wa == ra) d = wd;
`endif
                    rq.push_back('{cyc + 1, rj, d});
                    rlast = rj;
                end
                if (wj >= 0) begin
                    mem_m[wa] = wd;
                    wlast = wj;
                end
                if (zeroize) ready_at = cyc + 1 + DEPTH;
            end
            cyc++;
        end
    end

    initial begin : monitor
        int mcyc;
        rd_exp_t e;
        mcyc = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rd_valid != '0) begin
                if (rq.size() == 0) begin
                    chk("rd_valid_unexpected", 64'(rd_valid), 64'd0);
                end else begin
                    e = rq.pop_front();
                    chk("rd_due", 64'(mcyc), 64'(e.due));
                    chk("rd_valid", 64'(rd_valid), 64'd1 << e.idx);
                    chk("rd_data", 64'(rd_data), 64'(e.data));
                end
            end else begin
                chk("rd_data_idle", 64'(rd_data), 64'd0);
                if (rq.size() > 0 && rq[0].due <= mcyc) begin
                    e = rq.pop_front();
                    chk("rd_valid_missing", 64'(rd_valid), 64'd1 << e.idx);
                end
            end
            mcyc++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        wr_req = '0;
        rd_req = '0;
        zeroize = 1'b0;
    endtask

    task automatic randomize_reqs();
        wr_req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
        rd_req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
        for (int i = 0; i < NREQ; i++) begin
            wr_addr[i*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
            rd_addr[i*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
            wr_data[i*DW +: DW] = DW'($urandom);
        end
    endtask

    initial begin : stimulus
        tick(3);
        rst = 1'b0;
        // Requests held throughout the clear must see no grants
        for (int i = 0; i < DEPTH; i++) begin
            randomize_reqs();
            tick(1);
        end
        idle();
        for (int a = 0; a < DEPTH; a++) begin
            rd_req = 2'b01;
            rd_addr[0 +: AW] = AW'(a);
            tick(1);
        end
        idle();
        tick(1);

        // Two writers contending: requester 1 on addr 5, requester 0 on addr 6
        wr_req = 2'b11;
        wr_addr = {AW'(5), AW'(6)};
        for (int i = 0; i < 4; i++) begin
            wr_data = {DW'($urandom), DW'($urandom)};
            tick(1);
        end
        idle();
        rd_req = 2'b11;
        rd_addr = {AW'(6), AW'(5)};
        tick(2);
        idle();

        wr_req = 2'b01;
        wr_addr[0 +: AW] = AW'(3);
        wr_data[0 +: DW] = 32'hDEAD_BEEF;
        tick(1);
        idle();
        rd_req = 2'b10;
        rd_addr[AW +: AW] = AW'(3);
        tick(1);
        idle();
        tick(2);

        // Same-cycle write/read of addr 9
        wr_req = 2'b01;
        wr_addr[0 +: AW] = AW'(9);
        wr_data[0 +: DW] = 32'h1234_5678;
        rd_req = 2'b01;
        rd_addr[0 +: AW] = AW'(9);
        tick(1);
        wr_req = '0;
        tick(1);
        idle();
        tick(1);

        // Zeroize from READY, again at counter 20, requests held throughout
        zeroize = 1'b1;
        wr_req = 2'b11;
        rd_req = 2'b11;
        tick(1);
        zeroize = 1'b0;
        tick(20);
        zeroize = 1'b1;
        tick(1);
        zeroize = 1'b0;
        tick(DEPTH);
        wr_req = '0;
        rd_req = 2'b01;
        rd_addr[0 +: AW] = AW'(3);
        tick(1);
        zeroize = 1'b1;
        tick(1);
        idle();
        tick(DEPTH + 2);

        // Reset the cycle after a read grant
        rd_req = 2'b01;
        rd_addr[0 +: AW] = AW'(4);
        tick(1);
        rst = 1'b1;
        rd_req = '0;
        tick(1);
        rst = 1'b0;
        rd_req = 2'b11;
        rd_addr = {AW'(2), AW'(1)};
        tick(DEPTH + 3);
        idle();

        for (int i = 0; i < 600; i++) begin
            randomize_reqs();
            rst = ($urandom_range(0, 249) == 0);
            zeroize = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        rst = 1'b0;
        idle();
        tick(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/abr_1r1w_ram_arb.md
# abr_1r1w_ram_arb

Arbiter and sequencer for a single 1-read/1-write synchronous RAM shared by NUM_REQ read requesters and NUM_REQ write requesters.
- Each port side has an independent round-robin arbiter with a request/grant handshake.
- Read data returns one cycle after grant, with a per-requester valid.
- A clear state machine zero-fills the RAM after reset and on zeroize.
- The block sits between datapath engines and the RAM macro, and is the only master of the RAM ports.

## Interface
Parameters:
- DEPTH, 64, number of RAM words (need not be a power of two)
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, $clog2(DEPTH), address width
- NUM_REQ, 2, requesters per side (2..8)

Ports:
- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- zeroize_i  in  1  start (or restart) a full RAM clear
- busy_o  out  1  high while clearing
- wr_req_i  in  NUM_REQ  write requests
- wr_addr_i  in  NUM_REQ×ADDR_WIDTH  write address per requester
- wr_data_i  in  NUM_REQ×DATA_WIDTH  write data per requester
- wr_gnt_o  out  NUM_REQ  one-hot write grant
- rd_req_i  in  NUM_REQ  read requests
- rd_addr_i  in  NUM_REQ×ADDR_WIDTH  read address per requester
- rd_gnt_o  out  NUM_REQ  one-hot read grant
- rd_valid_o  out  NUM_REQ  one-hot, read data valid for that requester
- rd_data_o  out  DATA_WIDTH  read data, shared bus
- ram_we_o, ram_waddr_o, ram_wdata_o  out  1/ADDR_WIDTH/DATA_WIDTH  RAM write port
- ram_re_o, ram_raddr_o  out  1/ADDR_WIDTH  RAM read port
- ram_rdata_i  in  DATA_WIDTH  RAM read data, registered inside the RAM, valid the cycle after ram_re_o

## Operation
- FSM states: CLEAR and READY.
  - Reset enters CLEAR with the clear counter at 0.
  - In CLEAR, each cycle writes 0 to address = counter, then increments the counter.
  - After address DEPTH-1 is written, the next state is READY.
  - zeroize_i in READY moves to CLEAR next cycle with the counter at 0.
  - zeroize_i during CLEAR restarts the counter at 0.
- Grants:
  - Grants are combinational from requests.
  - They are issued only in READY with zeroize_i low and rst_i low.
  - All grants are 0 otherwise; requesters keep requesting.
- Arbitration, per side independently:
  - Round-robin: the search starts at the requester after the last granted index.
  - The pointer updates only on a grant. It resets to NUM_REQ-1, so requester 0 has first priority.
- Write grant:
  - ram_we_o=1 with the granted requester's address and data.
  - In CLEAR: ram_we_o=1, ram_waddr_o=counter, ram_wdata_o=0.
- Read grant:
  - ram_re_o=1 with the granted address.
  - The granted index is registered. Next cycle, rd_valid_o asserts that index and rd_data_o=ram_rdata_i.
- rd_data_o is forced to 0 whenever rd_valid_o is all-zero.
- A read granted in the cycle before CLEAR starts still completes normally.
- A read and a write to the same address in the same cycle return the old data (read-first), unless forwarding is compiled in (see Configuration).
- Out-of-range addresses (≥DEPTH) are passed through unchanged. Requesters are responsible for address range.

## Timing
- Reset values: busy_o=1, wr_gnt_o=0, rd_gnt_o=0, rd_valid_o=0, rd_data_o=0, ram_we_o=0, ram_re_o=0. RAM port address and data are 0 while rst_i is high.
- Clear takes exactly DEPTH cycles after rst_i deasserts. The first grant is possible in cycle DEPTH.
- Grant latency is 0 cycles (same cycle as request). Read-data latency is 1 cycle after grant.
- Throughput: one read and one write per cycle.
- The handshake completes at the clock edge where req&gnt is high. The requester may change address or data, or drop the request, after that edge.
- busy_o deasserts in the first READY cycle.
- rst_i asserted mid-operation:
  - In-flight rd_valid_o is dropped (0 next cycle).
  - The FSM returns to CLEAR and the pointers return to reset values.

## Configuration
- ABR_RAM_ARB_FWD_EN defined: a read granted in the same cycle as a write to an equal address returns the write data, which is registered and muxed onto rd_data_o with the normal 1-cycle latency.
- ABR_RAM_ARB_FWD_EN undefined: no forwarding logic; same-address collisions return the previous RAM contents.

## Test plan
- Reset, then preload RAM with nonzero data. Release reset with DEPTH=64 -> busy_o=1 for 64 cycles, every address reads 0 afterwards, and no grant is issued during clear.
- Both write requesters hold requests for 4 cycles, with requester 1 writing addr 5 and requester 0 writing addr 6 -> grants alternate 0,1,0,1; reads of 5 and 6 return the data from the last grant to each.
- Requester 1 reads addr 3, which holds 0xDEADBEEF -> rd_gnt_o=2'b10 in the same cycle; next cycle rd_valid_o=2'b10 and rd_data_o=0xDEADBEEF, with rd_data_o=0 on other cycles.
- Same-cycle write of 0x12345678 to addr 9 (old value 0x0) and read of addr 9 -> returns 0x0 without ABR_RAM_ARB_FWD_EN and 0x12345678 with it.
- zeroize_i pulsed mid-clear at counter 20, then pulsed again in READY with a pending read -> counter restarts at 0 and the pending read's valid still arrives. Clear lasts a full DEPTH cycles from the last pulse, and all requests are held without grants.
- rst_i asserted the cycle after a read grant -> rd_valid_o stays 0, the FSM re-enters CLEAR, and after clear, simultaneous read requests from 0 and 1 grant 0 first.
